// File: rtl/rat_recovery_ctrl.sv
// rat_recovery_ctrl: rebuilds the speculative RAT from the retirement map after a flush
module rat_recovery_ctrl #(
    parameter int NUM_ARCH_REGISTERS = 32,
    parameter int PHYS_REG_WIDTH = 6,
    parameter int CNT_WIDTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush_req,
    output logic [$clog2(NUM_ARCH_REGISTERS)-1:0] rrf_rd_addr,
    input  logic [PHYS_REG_WIDTH-1:0]             rrf_rd_data,
    output logic                                  rat_wen,
    output logic [$clog2(NUM_ARCH_REGISTERS)-1:0] rat_waddr,
    output logic [PHYS_REG_WIDTH-1:0]             rat_wdata,
    output logic                                  rat_wready,
    output logic                                  fl_restore,
    output logic                                  commit_hold,
    output logic                                  busy,
    output logic                                  done,
    output logic [CNT_WIDTH-1:0]                  recovery_count
);
    localparam int AW = $clog2(NUM_ARCH_REGISTERS);
    localparam logic [AW-1:0] LAST = AW'(NUM_ARCH_REGISTERS - 1);

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    state_t        state;
    logic [AW-1:0] idx;

    // sequence the walk; a flush in any state (re)starts it from index 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            recovery_count <= '0;
        end else if (flush_req) begin
            state          <= WALK;
            idx            <= '0;
            recovery_count <= (recovery_count == '1) ? recovery_count : recovery_count + 1'b1;
        end else begin
            state <= (state == WALK) ? ((idx == LAST) ? DONE : WALK) : IDLE;
            idx   <= (state == WALK && idx != LAST) ? idx + 1'b1 : '0;
        end
    end

    // decode the RAT write port and handshakes from the current walk position
    always_comb begin
        rat_wen     = (state == WALK);
        rrf_rd_addr = rat_wen ? idx : '0;
        rat_waddr   = rrf_rd_addr;
        rat_wdata   = rat_wen ? rrf_rd_data : '0;
        rat_wready  = rat_wen;
        fl_restore  = rat_wen && (idx == '0);
        done        = (state == DONE);
        commit_hold = (state != IDLE) || (flush_req && !rst);
        busy        = commit_hold;
    end
endmodule

// File: tb/tb_rat_recovery_ctrl.sv
// tb_rat_recovery_ctrl: directed bench with a cycle-schedule reference model
module tb_rat_recovery_ctrl;
    localparam int N = 32;

    logic       clk = 0;
    logic       rst = 1;
    logic       flush_req = 0;
    logic [5:0] rrf [N];

    logic [4:0]  rrf_rd_addr, rat_waddr, s_rrf_rd_addr, s_rat_waddr;
    logic [5:0]  rrf_rd_data, rat_wdata, s_rrf_rd_data, s_rat_wdata;
    logic        rat_wen, rat_wready, fl_restore, commit_hold, busy, done;
    logic        s_rat_wen, s_rat_wready, s_fl_restore, s_commit_hold, s_busy, s_done;
    logic [15:0] recovery_count;
    logic [1:0]  s_recovery_count;

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, start = 0, nflush = 0;
    bit started = 0, chk_en = 0;

    assign rrf_rd_data   = rrf[rrf_rd_addr];
    assign s_rrf_rd_data = rrf[s_rrf_rd_addr];

    rat_recovery_ctrl dut (
        .clk(clk), .rst(rst), .flush_req(flush_req),
        .rrf_rd_addr(rrf_rd_addr), .rrf_rd_data(rrf_rd_data),
        .rat_wen(rat_wen), .rat_waddr(rat_waddr), .rat_wdata(rat_wdata), .rat_wready(rat_wready),
        .fl_restore(fl_restore), .commit_hold(commit_hold), .busy(busy), .done(done),
        .recovery_count(recovery_count)
    );

    rat_recovery_ctrl #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .flush_req(flush_req),
        .rrf_rd_addr(s_rrf_rd_addr), .rrf_rd_data(s_rrf_rd_data),
        .rat_wen(s_rat_wen), .rat_waddr(s_rat_waddr), .rat_wdata(s_rat_wdata), .rat_wready(s_rat_wready),
        .fl_restore(s_fl_restore), .commit_hold(s_commit_hold), .busy(s_busy), .done(s_done),
        .recovery_count(s_recovery_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // reference schedule: a flush accepted at an edge starts a walk in the following cycle
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            started = 0;
            nflush  = 0;
        end else if (flush_req) begin
            started = 1;
            start   = cyc;
            nflush++;
        end
    end

    // every-cycle comparison against the schedule
    always begin
        int k;
        bit w, d;
        logic [5:0] exp_data;
        @(negedge clk);
        #2;
        if (chk_en) begin
            k = started ? cyc - start : -1;
            w = (k >= 0) && (k < N);
            d = (k == N);
            exp_data = w ? rrf[k[4:0]] : 6'd0;
            check("rat_wen", rat_wen, w);
            check("rrf_rd_addr", rrf_rd_addr, w ? k : 0);
            check("rat_waddr", rat_waddr, w ? k : 0);
            check("rat_wdata", rat_wdata, exp_data);
            check("rat_wready", rat_wready, w);
            check("fl_restore", fl_restore, w && k == 0);
            check("done", done, d);
            check("commit_hold", commit_hold, w || d || (flush_req && !rst));
            check("busy", busy, w || d || (flush_req && !rst));
            check("recovery_count", recovery_count, nflush > 65535 ? 65535 : nflush);
            check("sat_count", s_recovery_count, nflush > 3 ? 3 : nflush);
            check("sat_done", s_done, d);
        end
    end

    task automatic pulse_flush(output int t);
        @(negedge clk);
        flush_req = 1;
        t = cyc;
        @(negedge clk);
        flush_req = 0;
    endtask

    task automatic wait_done(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #2;
            if (done === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_addr(input int a, output logic [5:0] d, output logic r);
        d = 'x;
        r = 'x;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #2;
            if (rat_wen === 1'b1 && rat_waddr == a) begin
                d = rat_wdata;
                r = rat_wready;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int t, t2, at;
        logic [5:0] d;
        logic r;
        for (int i = 0; i < N; i++) rrf[i] = 6'(i);
        repeat (2) @(negedge clk);
        rst = 0;
        chk_en = 1;
        #2;
        check("reset_count", recovery_count, 0);
        check("reset_busy", busy, 0);
        check("reset_wen", rat_wen, 0);

        // basic identity walk
        pulse_flush(t);
        #2;
        check("basic_fl_restore", fl_restore, 1);
        check("basic_first_addr", rat_waddr, 0);
        wait_done(40, at);
        check("basic_done_cycle", at, t + 33);
        check("basic_count", recovery_count, 1);
        @(negedge clk);
        #2;
        check("basic_busy_low", busy, 0);

        // remapped retirement entries
        rrf[5] = 6'd40;
        rrf[31] = 6'd63;
        pulse_flush(t);
        wait_addr(5, d, r);
        check("remap_idx5", d, 40);
        check("remap_ready5", r, 1);
        wait_addr(31, d, r);
        check("remap_idx31", d, 63);
        check("remap_ready31", r, 1);
        wait_done(5, at);
        check("remap_done_cycle", at, t + 33);

        // restart ten cycles into a walk
        pulse_flush(t);
        repeat (8) @(negedge clk);
        pulse_flush(t2);
        #2;
        check("restart_fl_restore", fl_restore, 1);
        check("restart_idx", rat_waddr, 0);
        wait_done(60, at);
        check("restart_done_cycle", at, t + 43);
        check("restart_count", recovery_count, 4);

        // commit landing at the flush edge
        @(negedge clk);
        flush_req = 1;
        t = cyc;
        @(posedge clk);
        rrf[3] = 6'd17;
        @(negedge clk);
        flush_req = 0;
        wait_addr(3, d, r);
        check("commit_idx3", d, 17);
        wait_done(40, at);
        check("commit_done_cycle", at, t + 33);

        // reset mid-walk, with a colliding flush that must lose
        pulse_flush(t);
        repeat (14) @(negedge clk);
        rst = 1;
        flush_req = 1;
        @(negedge clk);
        rst = 0;
        flush_req = 0;
        #2;
        check("rst_wen", rat_wen, 0);
        check("rst_count", recovery_count, 0);
        check("rst_busy", busy, 0);
        wait_done(40, at);
        check("rst_no_done", at, -1);

        // saturation of the narrow counter
        for (int i = 1; i <= 5; i++) begin
            pulse_flush(t);
            #2;
            check("sat_lit", s_recovery_count, i > 3 ? 3 : i);
            repeat (3) @(negedge clk);
        end
        wait_done(40, at);
        flush_req = 1;
        @(negedge clk);
        flush_req = 0;
        #2;
        check("done_restart_fl", fl_restore, 1);
        check("done_restart_count", recovery_count, 6);
        wait_done(40, at);
        repeat (3) @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/rat_recovery_ctrl.md
RAT_RECOVERY_CTRL -- requirements
Module: rat_recovery_ctrl

Interface
REQ-001 Parameter NUM_ARCH_REGISTERS, default 32, number of architectural registers walked per recovery.
REQ-002 Parameter PHYS_REG_WIDTH, default 6, width of a physical register tag.
REQ-003 Parameter CNT_WIDTH, default 16, width of the recovery event counter.
REQ-004 clk  in  1  clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 flush_req  in  1  single-cycle pulse from the ROB head on a mispredict or exception flush.
REQ-007 rrf_rd_addr  out  $clog2(NUM_ARCH_REGISTERS)  architectural index presented to the retirement map read port.
REQ-008 rrf_rd_data  in  PHYS_REG_WIDTH  committed physical tag for rrf_rd_addr, combinational same-cycle return.
REQ-009 rat_wen  out  1  speculative RAT write enable.
REQ-010 rat_waddr  out  $clog2(NUM_ARCH_REGISTERS)  speculative RAT write index.
REQ-011 rat_wdata  out  PHYS_REG_WIDTH  physical tag written into the RAT.
REQ-012 rat_wready  out  1  ready bit written alongside rat_wdata; always 1 when rat_wen is 1.
REQ-013 fl_restore  out  1  single-cycle pulse telling the free list to roll its head back to its retirement pointer.
REQ-014 commit_hold  out  1  blocks ROB commit, and therefore RRF writes, while high.
REQ-015 busy  out  1  stalls rename/dispatch while high.
REQ-016 done  out  1  single-cycle pulse marking the end of a recovery.
REQ-017 recovery_count  out  CNT_WIDTH  number of recoveries started since reset.

Function
REQ-018 The FSM SHALL have three states: IDLE, WALK and DONE.
REQ-019 IDLE SHALL go to WALK on the cycle after flush_req=1; otherwise it SHALL stay in IDLE.
REQ-020 The walk index idx SHALL be loaded with 0 on the IDLE->WALK transition.
REQ-021 In WALK, rrf_rd_addr, rat_waddr and idx SHALL be equal, rat_wen SHALL be 1 and rat_wdata SHALL equal rrf_rd_data.
REQ-022 In WALK, idx SHALL increment by 1 per cycle; when idx==NUM_ARCH_REGISTERS-1 the next state SHALL be DONE.
REQ-023 A recovery SHALL therefore issue exactly NUM_ARCH_REGISTERS RAT writes on consecutive cycles, covering indices 0..N-1 in ascending order.
REQ-024 DONE SHALL last exactly one cycle, with done=1 and rat_wen=0, and SHALL then return to IDLE.
REQ-025 fl_restore SHALL be 1 only on the first WALK cycle (idx==0).
REQ-026 commit_hold SHALL be 1 in the cycle flush_req is seen in IDLE, and in every WALK and DONE cycle.
REQ-027 busy SHALL equal commit_hold.
REQ-028 Outside WALK: rat_wen=0; rrf_rd_addr, rat_waddr and rat_wdata SHALL be 0.
REQ-029 flush_req during WALK or DONE SHALL restart the walk: next state WALK, idx=0, and fl_restore pulses again.
REQ-030 recovery_count SHALL increment on every transition into WALK, including restarts.
REQ-031 recovery_count SHALL saturate at all-ones.
REQ-032 Any commit that coincides with flush_req has written the RRF at that same edge, so the walk SHALL read post-commit mappings.
REQ-033 The end-to-end latency SHALL be: flush_req at cycle T gives the first RAT write at T+1, done at T+N+1, and busy low at T+N+2.

Reset
REQ-034 rst SHALL force state IDLE, idx 0 and recovery_count 0.
REQ-035 After rst, every output SHALL read 0 on the following cycle.
REQ-036 rst asserted mid-WALK SHALL abort the walk with no further RAT writes and no done pulse.
REQ-037 rst SHALL take priority over flush_req.

Verification
REQ-038 Basic walk: RRF holds the identity map (i->i), pulse flush_req at T -> RAT writes 0->0 through 31->31 over T+1..T+32, fl_restore at T+1, done at T+33, recovery_count=1.
REQ-039 Remapped RRF: set RRF[5]=40 and RRF[31]=63, then flush -> write cycle for idx 5 carries rat_wdata=40 and idx 31 carries 63, with rat_wready=1 on every write.
REQ-040 Restart: second flush_req at T+10 -> idx back to 0 at T+11, fl_restore again, 32 further writes, done at T+43, recovery_count=2.
REQ-041 Reset mid-walk: rst at T+15 -> all outputs 0 from T+16 on, no done pulse, recovery_count=0.
REQ-042 Commit coincident with flush: RRF[3] updated to 17 at the same edge as flush_req -> the idx 3 write carries 17; commit_hold stays high from T through T+33.
REQ-043 Saturation: with CNT_WIDTH=2, run 5 flushes -> recovery_count reads 3 after the third flush and stays at 3.
